ram_arbiter: RTL

- Shares the single-port synchronous RAM between two requesters: the instruction-fetch stage (read only) and the data/memory stage (read or write).
- Serialises their transactions and drives the RAM's write_enable/address/data_in.
- Captures the RAM's registered data_out and returns it to the granted requester with a one-cycle ready pulse.
- Replaces ad-hoc per-stage RAM access with a single, deterministic owner of the RAM interface.

---
 rtl/ram_arbiter_pkg.sv | 17 +
 rtl/ram_arbiter_if.sv | 46 ++++
 rtl/ram_arbiter_rr_pick.sv | 26 ++
 rtl/ram_arbiter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// State encoding, grant ids and default widths.
package ram_arbiter_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 8;

    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side bundle of the arbiter.
// master = requesters/RAM side, slave = arbiter.
interface ram_arbiter_if
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic [DATA_W-1:0] fetch_rdata;
    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_ready;
    logic [DATA_W-1:0] data_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              grant;

    modport master (
        output fetch_req, fetch_addr,
        output data_req, data_we, data_addr, data_wdata,
        output mem_rdata,
        input  fetch_ready, fetch_rdata,
        input  data_ready, data_rdata,
        input  mem_we, mem_addr, mem_wdata,
        input  busy, grant
    );

    modport slave (
        input  fetch_req, fetch_addr,
        input  data_req, data_we, data_addr, data_wdata,
        input  mem_rdata,
        output fetch_ready, fetch_rdata,
        output data_ready, data_rdata,
        output mem_we, mem_addr, mem_wdata,
        output busy, grant
    );

endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// Two-way winner select between fetch and data requesters.
// Alternates against the last grant on ties when RR_EN is set.
module ram_arbiter_rr_pick
    import ram_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
)(
    input  logic i_fetch_req,
    input  logic i_data_req,
    input  logic i_grant,
    output logic o_valid,
    output logic o_winner
);

    // Winner: sole requester, else alternate or fetch-first on a tie.
    always_comb begin
        o_valid  = i_fetch_req | i_data_req;
        o_winner = GRANT_FETCH;
        if (i_fetch_req && i_data_req) begin
            o_winner = RR_EN ? ~i_grant : GRANT_FETCH;
        end else if (i_data_req) begin
            o_winner = GRANT_DATA;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Single owner of the synchronous RAM port, shared by fetch and data.
// IDLE -> ACCESS -> CAPTURE, one transaction every three cycles.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter bit RR_EN  = 1'b1
)(
    input logic          ram_clk,
    input logic          rst,
    ram_arbiter_if.slave bus
);

    state_t            r_state, w_state_nxt;
    logic              r_grant, w_grant_nxt;
    logic              r_wr, w_wr_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic              r_fetch_ready, w_fetch_ready_nxt;
    logic              r_data_ready, w_data_ready_nxt;
    logic [DATA_W-1:0] r_fetch_rdata, w_fetch_rdata_nxt;
    logic [DATA_W-1:0] r_data_rdata, w_data_rdata_nxt;
    logic              w_req_any;
    logic              w_winner;

    ram_arbiter_rr_pick #(
        .RR_EN (RR_EN)
    ) u_pick (
        .i_fetch_req (bus.fetch_req),
        .i_data_req  (bus.data_req),
        .i_grant     (r_grant),
        .o_valid     (w_req_any),
        .o_winner    (w_winner)
    );

    // Next state and next values of every registered output.
    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_wr_nxt          = r_wr;
        w_mem_we_nxt      = 1'b0;
        w_mem_addr_nxt    = r_mem_addr;
        w_mem_wdata_nxt   = r_mem_wdata;
        w_fetch_ready_nxt = 1'b0;
        w_data_ready_nxt  = 1'b0;
        w_fetch_rdata_nxt = r_fetch_rdata;
        w_data_rdata_nxt  = r_data_rdata;
        unique case (r_state)
            IDLE: begin
                if (w_req_any) begin
                    w_state_nxt = ACCESS;
                    w_grant_nxt = w_winner;
                    if (w_winner == GRANT_DATA) begin
                        w_wr_nxt        = bus.data_we;
                        w_mem_we_nxt    = bus.data_we;
                        w_mem_addr_nxt  = bus.data_addr;
                        w_mem_wdata_nxt = bus.data_wdata;
                    end else begin
                        w_wr_nxt        = 1'b0;
                        w_mem_addr_nxt  = bus.fetch_addr;
                        w_mem_wdata_nxt = '0;
                    end
                end
            end
            ACCESS: begin
                w_state_nxt = CAPTURE;
            end
            CAPTURE: begin
                w_state_nxt = IDLE;
                if (r_grant == GRANT_DATA) begin
                    w_data_ready_nxt = 1'b1;
                    if (!r_wr) begin
                        w_data_rdata_nxt = bus.mem_rdata;
                    end
                end else begin
                    w_fetch_ready_nxt = 1'b1;
                    w_fetch_rdata_nxt = bus.mem_rdata;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight access at once.
    always_ff @(posedge ram_clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_grant       <= GRANT_DATA;
            r_wr          <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_fetch_ready <= 1'b0;
            r_data_ready  <= 1'b0;
            r_fetch_rdata <= '0;
            r_data_rdata  <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_wr          <= w_wr_nxt;
            r_mem_we      <= w_mem_we_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_mem_wdata   <= w_mem_wdata_nxt;
            r_fetch_ready <= w_fetch_ready_nxt;
            r_data_ready  <= w_data_ready_nxt;
            r_fetch_rdata <= w_fetch_rdata_nxt;
            r_data_rdata  <= w_data_rdata_nxt;
        end
    end

    assign bus.mem_we      = r_mem_we;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.fetch_ready = r_fetch_ready;
    assign bus.fetch_rdata = r_fetch_rdata;
    assign bus.data_ready  = r_data_ready;
    assign bus.data_rdata  = r_data_rdata;
    assign bus.busy        = (r_state != IDLE);
    assign bus.grant       = r_grant;

endmodule
